// File: rtl/alu_secuencial.sv
// Registered ALU with valid/ready handshakes and status flags.
// MUL is an iterative shift-add that processes one multiplier bit per cycle.
module alu_secuencial #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] Ope1,
    input  logic [WIDTH-1:0] Ope2,
    input  logic [2:0]       AluOp,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Resultado,
    output logic             Cero,
    output logic             Acarreo,
    output logic             Desborde
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_XOR    = 3'b011;
    localparam logic [2:0] OP_MUL    = 3'b100;
    localparam logic [2:0] OP_SLL    = 3'b101;
    localparam logic [2:0] OP_SUB    = 3'b110;
    localparam logic [2:0] OP_MAYORQ = 3'b111;

    localparam logic [SHW-1:0] LAST_BIT = SHW'(WIDTH - 1);

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc_next;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     dif;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;

    assign InReady  = (state == IDLE);
    assign OutValid = (state == DONE);

    // Single-cycle ops are evaluated straight from the inputs on the accept edge.
    always_comb begin
        sum     = {1'b0, Ope1} + {1'b0, Ope2};
        dif     = {1'b0, Ope1} - {1'b0, Ope2};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (AluOp)
            OP_AND:    alu_res = Ope1 & Ope2;
            OP_OR:     alu_res = Ope1 | Ope2;
            OP_XOR:    alu_res = Ope1 ^ Ope2;
            OP_SLL:    alu_res = Ope1 << Ope2[SHW-1:0];
            OP_MAYORQ: alu_res = {{(WIDTH-1){1'b0}}, (Ope1 > Ope2)};
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (Ope1[WIDTH-1] == Ope2[WIDTH-1]) && (sum[WIDTH-1] != Ope1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = dif[WIDTH-1:0];
                alu_c   = dif[WIDTH];
                alu_v   = (Ope1[WIDTH-1] != Ope2[WIDTH-1]) && (dif[WIDTH-1] != Ope1[WIDTH-1]);
            end
            default: alu_res = '0;
        endcase
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            Resultado <= '0;
            Cero      <= 1'b0;
            Acarreo   <= 1'b0;
            Desborde  <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid) begin
                        if (AluOp == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{WIDTH{1'b0}}, Ope1};
                            mplier <= Ope2;
                            cnt    <= '0;
                            state  <= BUSY;
                        end else begin
                            Resultado <= alu_res;
                            Cero      <= (alu_res == '0);
                            Acarreo   <= alu_c;
                            Desborde  <= alu_v;
                            state     <= DONE;
                        end
                    end
                end
                // The last partial product is folded in on the same edge the result is registered.
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        Resultado <= acc_next[WIDTH-1:0];
                        Cero      <= (acc_next[WIDTH-1:0] == '0);
                        Acarreo   <= 1'b0;
                        Desborde  <= |acc_next[2*WIDTH-1:WIDTH];
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_secuencial.sv
// Self-checking bench for alu_secuencial: a latency/arithmetic model is compared
// against the DUT on every falling edge, plus directed literal checks.
module tb_alu_secuencial;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         InValid = 1'b0;
    logic         OutReady = 1'b0;
    logic [W-1:0] Ope1 = '0;
    logic [W-1:0] Ope2 = '0;
    logic [2:0]   AluOp = 3'b000;
    logic         InReady;
    logic         OutValid;
    logic [W-1:0] Resultado;
    logic         Cero;
    logic         Acarreo;
    logic         Desborde;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    alu_secuencial #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .InValid(InValid),
        .InReady(InReady),
        .Ope1(Ope1),
        .Ope2(Ope2),
        .AluOp(AluOp),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .Resultado(Resultado),
        .Cero(Cero),
        .Acarreo(Acarreo),
        .Desborde(Desborde)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         v;
    } ref_t;

    // Reference arithmetic: signed overflow is detected by comparing the exact
    // 64-bit signed result with the sign-extended truncated one.
    function automatic ref_t refOp(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ref_t        r;
        longint      sa;
        longint      sb;
        longint      sr;
        logic [63:0] p;
        logic [W:0]  wide;
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: r.res = a & b;
            3'b001: r.res = a | b;
            3'b011: r.res = a ^ b;
            3'b101: r.res = a << (b % W);
            3'b111: r.res = (a > b) ? 32'd1 : 32'd0;
            3'b010: begin
                wide  = {1'b0, a} + {1'b0, b};
                r.res = wide[W-1:0];
                r.c   = wide[W];
                sr    = sa + sb;
                r.v   = (sr != longint'($signed(r.res)));
            end
            3'b110: begin
                r.res = a - b;
                r.c   = (a < b);
                sr    = sa - sb;
                r.v   = (sr != longint'($signed(r.res)));
            end
            default: begin
                p     = {32'b0, a} * {32'b0, b};
                r.res = p[W-1:0];
                r.v   = (p[63:32] != 32'b0);
            end
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the outputs must show, tracked as a countdown to delivery.
    bit     m_ready = 1'b1;
    bit     m_valid = 1'b0;
    bit     m_z = 1'b0;
    int     pending = 0;
    ref_t   m_out = '0;
    ref_t   m_next = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_z     = 1'b0;
            pending = 0;
            m_out   = '0;
        end else if (m_valid) begin
            if (OutReady) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end else if (m_ready) begin
            if (InValid) begin
                m_next  = refOp(AluOp, Ope1, Ope2);
                m_ready = 1'b0;
                pending = (AluOp == 3'b100) ? W : 0;
                if (pending == 0) begin
                    m_out   = m_next;
                    m_z     = (m_next.res == '0);
                    m_valid = 1'b1;
                end
            end
        end else begin
            pending--;
            if (pending == 0) begin
                m_out   = m_next;
                m_z     = (m_next.res == '0);
                m_valid = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("InReady", 64'(InReady), 64'(m_ready));
            checkOutput("OutValid", 64'(OutValid), 64'(m_valid));
            checkOutput("Resultado", 64'(Resultado), 64'(m_out.res));
            checkOutput("Cero", 64'(Cero), 64'(m_z));
            checkOutput("Acarreo", 64'(Acarreo), 64'(m_out.c));
            checkOutput("Desborde", 64'(Desborde), 64'(m_out.v));
        end
    end

    // Issue one op, wait for its result, hold it for 'stall' cycles, then release it.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input int stall, input bit keepValid, output int lat);
        int n;
        n   = 0;
        lat = -1;
        @(negedge clk);
        while (!InReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!InReady) begin
            errors++;
            $display("[TB] FAIL idle_wait: InReady got 0 expected 1");
            return;
        end
        Ope1     = a;
        Ope2     = b;
        AluOp    = op;
        InValid  = 1'b1;
        OutReady = 1'b0;
        @(posedge clk);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (!keepValid) InValid = 1'b0;
            Ope1  = $urandom;
            Ope2  = $urandom;
            AluOp = 3'($urandom);
            if (OutValid) break;
        end
        InValid = 1'b0;
        if (!OutValid) begin
            errors++;
            $display("[TB] FAIL result_wait: OutValid got 0 expected 1");
            return;
        end
        repeat (stall) @(negedge clk);
        OutReady = 1'b1;
        @(negedge clk);
        OutReady = 1'b0;
    endtask

    task automatic checkOp(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall, input bit keepValid, input logic [W-1:0] expRes,
                           input bit expZ, input bit expC, input bit expV, input int expLat);
        int   lat;
        ref_t r;
        r = refOp(op, a, b);
        checkOutput({name, "_model"}, 64'(r.res), 64'(expRes));
        applyStimulus(op, a, b, stall, keepValid, lat);
        checkOutput({name, "_lat"}, 64'(lat), 64'(expLat));
        checkOutput({name, "_res"}, 64'(Resultado), 64'(expRes));
        checkOutput({name, "_cero"}, 64'(Cero), 64'(expZ));
        checkOutput({name, "_acarreo"}, 64'(Acarreo), 64'(expC));
        checkOutput({name, "_desborde"}, 64'(Desborde), 64'(expV));
    endtask

    logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 3))
            0:       return corners[$urandom_range(0, 4)];
            1:       return W'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        logic [2:0] op;
        repeat (3) @(negedge clk);
        checking = 1'b1;
        checkOutput("rst_inready", 64'(InReady), 64'd1);
        checkOutput("rst_outvalid", 64'(OutValid), 64'd0);
        checkOutput("rst_res", 64'(Resultado), 64'd0);
        checkOutput("rst_flags", 64'({Cero, Acarreo, Desborde}), 64'd0);
        #2 rst_n = 1'b1;

        checkOp("add_carry", 3'b010, 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 1, 1, 0, 1);
        checkOp("add_ovf", 3'b010, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 0, 1, 1);
        checkOp("sub_borrow", 3'b110, 32'd3, 32'd5, 0, 0, 32'hFFFFFFFE, 0, 1, 0, 1);
        checkOp("mayorq_gt", 3'b111, 32'd5, 32'd3, 0, 0, 32'd1, 0, 0, 0, 1);
        checkOp("mayorq_lt", 3'b111, 32'd3, 32'd5, 0, 0, 32'd0, 1, 0, 0, 1);
        checkOp("mayorq_uns", 3'b111, 32'h80000000, 32'd1, 0, 0, 32'd1, 0, 0, 0, 1);
        checkOp("mul_ovf", 3'b100, 32'h00010000, 32'h00010000, 0, 1, 32'h0, 1, 0, 1, 33);
        checkOp("mul_small", 3'b100, 32'd1234, 32'd5678, 0, 0, 32'd7006652, 0, 0, 0, 33);
        checkOp("mul_zero", 3'b100, 32'd0, 32'hDEADBEEF, 2, 0, 32'd0, 1, 0, 0, 33);
        checkOp("xor_stall", 3'b011, 32'hF0F0F0F0, 32'hFFFF0000, 5, 0, 32'h0F0FF0F0, 0, 0, 0, 1);
        checkOutput("xor_release_inready", 64'(InReady), 64'd1);
        checkOp("sll", 3'b101, 32'h1, 32'h25, 0, 0, 32'h20, 0, 0, 0, 1);
        checkOp("and", 3'b000, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 32'h0F000F00, 0, 0, 0, 1);
        checkOp("or", 3'b001, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 32'hFFF0FFF0, 0, 0, 0, 1);

        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom);
            applyStimulus(op, pickOperand(), pickOperand(), $urandom_range(0, 3), 1'($urandom), lat);
            checkOutput("rand_lat", 64'(lat), (op == 3'b100) ? 64'd33 : 64'd1);
        end

        // Reset in the middle of a multiply must discard it entirely.
        @(negedge clk);
        Ope1    = 32'd77;
        Ope2    = 32'd99;
        AluOp   = 3'b100;
        InValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        InValid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_inready", 64'(InReady), 64'd1);
        checkOutput("midrst_outvalid", 64'(OutValid), 64'd0);
        checkOutput("midrst_res", 64'(Resultado), 64'd0);
        checkOutput("midrst_flags", 64'({Cero, Acarreo, Desborde}), 64'd0);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("midrst_no_emit", 64'(OutValid), 64'd0);
        checkOutput("midrst_res_hold", 64'(Resultado), 64'd0);

        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
